ay_bus_master: RTL



---
 rtl/ay_bus_if.sv | 28 ++
 rtl/ay_bus_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ay_bus_if.sv
// Request/response and AY bus signals between the host-side initiator and the CPLD under test.
interface ay_bus_if;
  logic       req;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       err;
  logic       aybdir;
  logic       aybc2;
  logic       aybc1;
  logic       aya8;
  logic       aya9_n;
  logic [7:0] ayd_out;
  logic       ayd_oe;
  logic [7:0] ayd_in;

  modport master (
    input  req, cmd, wdata, ayd_in,
    output ready, done, rdata, err, aybdir, aybc2, aybc1, aya8, aya9_n, ayd_out, ayd_oe
  );

  modport slave (
    output req, cmd, wdata, ayd_in,
    input  ready, done, rdata, err, aybdir, aybc2, aybc1, aya8, aya9_n, ayd_out, ayd_oe
  );
endinterface

// File: rtl/ay_bus_master.sv
// AY-3-8910 bus initiator: runs timed write-address / write-data / read cycles from single requests.
// Optional macro AYBUS_CFGPORT_EN turns cmd 11 into a config-port write instead of an illegal command.
module ay_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 16,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned RECOV_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  ay_bus_if.master    bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                bdir_q, bdir_d;
  logic                bc2_q, bc2_d;
  logic                bc1_q, bc1_d;
  logic                a8_q, a8_d;
  logic                a9n_q, a9n_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                doe_q, doe_d;
  logic                active;
  logic                is_read;

  // State register and registered bus outputs; reset drives the idle bus code 010.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= 2'b00;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bdir_q  <= 1'b0;
      bc2_q   <= 1'b1;
      bc1_q   <= 1'b0;
      a8_q    <= 1'b0;
      a9n_q   <= 1'b1;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bdir_q  <= bdir_d;
      bc2_q   <= bc2_d;
      bc1_q   <= bc1_d;
      a8_q    <= a8_d;
      a9n_q   <= a9n_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  // Next state; each phase reloads the shared down-counter and ends when it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req && ready_q) begin
          cmd_d  = bus.cmd;
          data_d = bus.wdata;
          if (bus.cmd == 2'b11) begin
`ifdef AYBUS_CFGPORT_EN
            data_d  = {4'hF, bus.wdata[3:0]};
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CYC);
`else
            err_d   = 1'b1;
`endif
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CYC);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
          if (cmd_q == 2'b10) begin
            rdata_d = bus.ayd_in;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RECOV;
          cnt_d   = CNT_W'(RECOV_CYC);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECOV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus pins follow the next state so every phase appears on the same edge it is entered.
  always_comb begin
    active  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    is_read = (cmd_d == 2'b10);
    ready_d = (state_d == S_IDLE);
    bdir_d  = 1'b0;
    bc2_d   = 1'b1;
    bc1_d   = 1'b0;
    a8_d    = 1'b0;
    a9n_d   = 1'b1;
    doe_d   = 1'b0;
    dout_d  = '0;

    if (active) begin
      a8_d  = 1'b1;
      a9n_d = 1'b0;
      if (!is_read) begin
        doe_d  = 1'b1;
        dout_d = data_d;
      end
    end

    if (state_d == S_STROBE) begin
      case (cmd_d)
        2'b01:   {bdir_d, bc2_d, bc1_d} = 3'b110;
        2'b10:   {bdir_d, bc2_d, bc1_d} = 3'b011;
        default: {bdir_d, bc2_d, bc1_d} = 3'b111;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.aybdir  = bdir_q;
  assign bus.aybc2   = bc2_q;
  assign bus.aybc1   = bc1_q;
  assign bus.aya8    = a8_q;
  assign bus.aya9_n  = a9n_q;
  assign bus.ayd_out = dout_q;
  assign bus.ayd_oe  = doe_q;

endmodule
